weight_loader: RTL and testbench



---
 rtl/mlp_ctrl_pkg.sv | 27 ++
 rtl/weight_loader_beat_packer.sv | 43 ++++
 rtl/weight_loader.sv | 119 +++++++++++
 tb/tb_weight_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_ctrl_pkg.sv
// Shared types and constants for the MLP control blocks: loader FSM states
// and the post-reset weight fill patterns.
package mlp_ctrl_pkg;

    localparam int FILL_MAXW = 1024;

    localparam logic [7:0]  WEIGHT_INIT_0_BYTE = 8'h01;
    localparam logic [15:0] WEIGHT_INIT_1_HALF = 16'h0001;

    typedef enum logic [1:0] {
        INIT_FILL,
        IDLE,
        LOAD,
        FINISH
    } loader_state_t;

    // Pattern is built at the widest supported row; callers truncate to DATAW,
    // which is safe because both patterns repeat from bit 0.
    function automatic logic [FILL_MAXW-1:0] fill_pattern(input int sel);
        case (sel)
            0:       return {(FILL_MAXW/8){WEIGHT_INIT_0_BYTE}};
            1:       return {(FILL_MAXW/16){WEIGHT_INIT_1_HALF}};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/weight_loader_beat_packer.sv
// Packs INW-bit beats little-endian into a DATAW-bit row; flags the beat that
// completes a row and presents the finished row combinationally with it.
module beat_packer #(
    parameter int DATAW = 128,
    parameter int INW   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_fire,
    input  logic [INW-1:0]   in_data,
    output logic             row_valid,
    output logic [DATAW-1:0] row_data
);

    localparam int BEATS = DATAW / INW;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    logic [BW-1:0]    beat_q;
    logic [DATAW-1:0] pack_q;

    assign row_valid = in_fire && (beat_q == LAST_BEAT);

    // The final beat bypasses the register so the row is ready on its own edge.
    always_comb begin
        row_data = pack_q;
        row_data[DATAW-1 -: INW] = in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
            pack_q <= '0;
        end else if (clear) begin
            beat_q <= '0;
        end else if (in_fire) begin
            pack_q[int'(beat_q)*INW +: INW] <= in_data;
            beat_q <= row_valid ? '0 : beat_q + 1'b1;
        end
    end

endmodule

// File: rtl/weight_loader.sv
// Streams narrow weight words into packed rows and writes them sequentially
// into a memory_block write port; optionally pre-fills the memory after reset.
module weight_loader
    import mlp_ctrl_pkg::*;
#(
    parameter int DATAW    = 128,
    parameter int DEPTH    = 64,
    parameter int ADDRW    = $clog2(DEPTH),
    parameter int INW      = 32,
    parameter int INIT_SEL = -1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ADDRW:0]   num_rows,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INW-1:0]   in_data,
    output logic [ADDRW-1:0] mem_waddr,
    output logic             mem_wen,
    output logic [DATAW-1:0] mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             init_done
);

    localparam loader_state_t  RESET_STATE = (INIT_SEL >= 0) ? INIT_FILL : IDLE;
    localparam logic [DATAW-1:0] PATTERN   = DATAW'(fill_pattern(INIT_SEL));
    localparam logic [ADDRW:0] DEPTH_W     = (ADDRW+1)'(DEPTH);
    localparam logic [ADDRW:0] LAST_ROW    = (ADDRW+1)'(DEPTH - 1);

    loader_state_t    state_q, state_d;
    logic [ADDRW:0]   row_q;
    logic [ADDRW:0]   nrows_q;
    logic [ADDRW:0]   num_clamped;
    logic             start_acc;
    logic             fire;
    logic             row_valid;
    logic [DATAW-1:0] row_data;

    assign num_clamped = (num_rows > DEPTH_W) ? DEPTH_W : num_rows;
    assign start_acc   = (state_q == IDLE) && start;
    assign fire        = in_valid && in_ready;

    beat_packer #(
        .DATAW (DATAW),
        .INW   (INW)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst),
        .clear     (start_acc),
        .in_fire   (fire),
        .in_data   (in_data),
        .row_valid (row_valid),
        .row_data  (row_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= RESET_STATE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT_FILL: if (row_q == LAST_ROW) state_d = IDLE;
            IDLE:      if (start) state_d = (num_clamped == '0) ? FINISH : LOAD;
            LOAD:      if (row_valid && (row_q == nrows_q - 1'b1)) state_d = FINISH;
            FINISH:    state_d = IDLE;
            default:   state_d = RESET_STATE;
        endcase
    end

    // Status outputs are registered from the next state so they are glitch-free
    // and read as zero while reset is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q     <= '0;
            nrows_q   <= '0;
            mem_waddr <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b0;
            init_done <= 1'(INIT_SEL < 0);
        end else begin
            mem_wen  <= 1'b0;
            busy     <= (state_d != IDLE);
            in_ready <= (state_d == LOAD);
            done     <= (state_d == FINISH);
            if (state_q == IDLE) init_done <= 1'b1;
            case (state_q)
                INIT_FILL: begin
                    mem_wen   <= 1'b1;
                    mem_waddr <= row_q[ADDRW-1:0];
                    mem_wdata <= PATTERN;
                    row_q     <= row_q + 1'b1;
                end
                IDLE: begin
                    if (start) begin
                        nrows_q <= num_clamped;
                        row_q   <= '0;
                    end
                end
                LOAD: begin
                    if (row_valid) begin
                        mem_wen   <= 1'b1;
                        mem_waddr <= row_q[ADDRW-1:0];
                        mem_wdata <= row_data;
                        row_q     <= row_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Randomized bench for weight_loader: two instances (fill patterns 0 and 1)
// share stimulus and are compared cycle by cycle against a row-level model.
module tb_weight_loader;

    localparam logic [127:0] PAT0 = {16{8'h01}};
    localparam logic [127:0] PAT1 = {8{16'h0001}};

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [6:0]   num_rows;
    logic         in_valid;
    logic [31:0]  in_data;

    logic         ready0, wen0, busy0, done0, idone0;
    logic [5:0]   waddr0;
    logic [127:0] wdata0;
    logic         ready1, wen1, busy1, done1, idone1;
    logic [5:0]   waddr1;
    logic [127:0] wdata1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]  words [0:255];
    int           last_addr;
    logic [127:0] last_d0, last_d1;

    always #5 clk = ~clk;

    weight_loader #(
        .DATAW    (128),
        .DEPTH    (64),
        .INW      (32),
        .INIT_SEL (0)
    ) dut0 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_rows  (num_rows),
        .in_valid  (in_valid),
        .in_ready  (ready0),
        .in_data   (in_data),
        .mem_waddr (waddr0),
        .mem_wen   (wen0),
        .mem_wdata (wdata0),
        .busy      (busy0),
        .done      (done0),
        .init_done (idone0)
    );

    weight_loader #(
        .DATAW    (128),
        .DEPTH    (64),
        .INW      (32),
        .INIT_SEL (1)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_rows  (num_rows),
        .in_valid  (in_valid),
        .in_ready  (ready1),
        .in_data   (in_data),
        .mem_waddr (waddr1),
        .mem_wen   (wen1),
        .mem_wdata (wdata1),
        .busy      (busy1),
        .done      (done1),
        .init_done (idone1)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input bit wen, input int addr,
                             input logic [127:0] d0, input logic [127:0] d1,
                             input bit dn, input bit rdy, input bit bsy, input bit idn);
        check({tag, "/wen0"},   wen0,   wen);
        check({tag, "/wen1"},   wen1,   wen);
        check({tag, "/addr0"},  waddr0, addr);
        check({tag, "/addr1"},  waddr1, addr);
        check({tag, "/data0"},  wdata0, d0);
        check({tag, "/data1"},  wdata1, d1);
        check({tag, "/done0"},  done0,  dn);
        check({tag, "/done1"},  done1,  dn);
        check({tag, "/ready0"}, ready0, rdy);
        check({tag, "/ready1"}, ready1, rdy);
        check({tag, "/busy0"},  busy0,  bsy);
        check({tag, "/busy1"},  busy1,  bsy);
        check({tag, "/idone0"}, idone0, idn);
        check({tag, "/idone1"}, idone1, idn);
    endtask

    task automatic check_zero(input string tag);
        check_out(tag, 0, 0, '0, '0, 0, 0, 0, 0);
    endtask

    // Post-reset fill: DEPTH consecutive writes; start is held high and must be ignored.
    task automatic fill_phase();
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            check_out("fill", 1, k, PAT0, PAT1, 0, 0, k < 63, 0);
            start    = (k < 60);
            num_rows = 7'd1;
            in_valid = 1'b1;
            in_data  = $urandom;
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        last_addr = 63;
        last_d0   = PAT0;
        last_d1   = PAT1;
        @(negedge clk);
        check_out("fill_end", 0, last_addr, last_d0, last_d1, 0, 0, 0, 1);
    endtask

    task automatic run_load(input int req, input int stall_pct, input int inject_at,
                            input int reset_at, input bit fixed);
        int n, total, i, cyc, prow;
        bit pend, fin;
        logic [127:0] row;
        n = (req > 64) ? 64 : req;
        total = n * 4;
        for (int k = 0; k < total; k++)
            words[k] = fixed ? 32'h1111_1111 * (k + 1) : $urandom;

        @(negedge clk);
        start    = 1'b1;
        num_rows = 7'(req);
        in_valid = 1'b1;
        in_data  = 32'hdead_beef;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;

        if (n == 0) begin
            check_out("zero_rows", 0, last_addr, last_d0, last_d1, 1, 0, 1, 1);
            @(negedge clk);
            check_out("zero_rows_end", 0, last_addr, last_d0, last_d1, 0, 0, 0, 1);
            return;
        end

        i = 0; cyc = 0; pend = 0; prow = 0;
        forever begin
            fin = pend && (prow == n - 1);
            if (pend) begin
                row = {words[4*prow+3], words[4*prow+2], words[4*prow+1], words[4*prow]};
                last_addr = prow;
                last_d0   = row;
                last_d1   = row;
            end
            check_out("load", pend, last_addr, last_d0, last_d1, fin, !fin, 1, 1);
            if (fin) break;
            if (cyc > 3000) begin
                check("load_timeout", i, total);
                break;
            end
            pend = 0;
            if (reset_at >= 0 && i == reset_at) begin
                rst      = 1'b0;
                in_valid = 1'b0;
                #1;
                check_zero("reset_mid");
                return;
            end
            start    = (cyc == inject_at);
            if (start) num_rows = 7'($urandom_range(127));
            in_valid = ($urandom_range(99) >= stall_pct);
            in_data  = words[i];
            @(posedge clk);
            if (in_valid) begin
                if (i % 4 == 3) begin
                    pend = 1;
                    prow = i / 4;
                end
                i++;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_out("after_done", 0, last_addr, last_d0, last_d1, 0, 0, 0, 1);
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        num_rows = '0;
        in_valid = 1'b0;
        in_data  = '0;
        last_addr = 0;
        last_d0   = '0;
        last_d1   = '0;

        repeat (2) @(negedge clk);
        #1 check_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        fill_phase();

        run_load(1, 0, -1, -1, 1);
        check("single_row_data", last_d0, 128'h44444444_33333333_22222222_11111111);
        run_load(3, 50, -1, -1, 0);
        run_load(0, 0, -1, -1, 0);
        run_load(100, 20, -1, -1, 0);
        check("clamp_last_addr", waddr0, 63);
        run_load(4, 30, 3, -1, 0);
        run_load(8, 0, -1, 22, 0);
        repeat (2) @(negedge clk);
        #1 check_zero("reset_hold");
        @(negedge clk);
        rst = 1'b1;
        fill_phase();
        run_load(2, 25, -1, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
